regfile_mp: RTL and testbench

//  Parametrised multi-port GPR file. Successor to the single-write-port CPU register file.

---
 rtl/regfile_mp.sv | 106 ++++++++++
 tb/tb_regfile_mp.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port GPR file: NR combinational read ports, two byte-enabled write ports and a busy-bit scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and write-clears onto the read ports.
module regfile_mp #(
    parameter int DW   = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NR   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NR*AW-1:0]     ra,
    output logic [NR*DW-1:0]     rd,
    output logic [NR-1:0]        rd_busy,
    input  logic [DW/8-1:0]      we0,
    input  logic [AW-1:0]        wa0,
    input  logic [DW-1:0]        wd0,
    input  logic [DW/8-1:0]      we1,
    input  logic [AW-1:0]        wa1,
    input  logic [DW-1:0]        wd1,
    input  logic [1:0]           iss_en,
    input  logic [2*AW-1:0]      iss_a
);

    localparam int          NB     = DW / 8;
    localparam logic [AW:0] NREG_W = (AW + 1)'(NREG);

    logic [DW-1:0]   mem [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;

    // Register 0 and addresses beyond the implemented range never hold state.
    function automatic logic in_range(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < NREG_W);
    endfunction

    // Per-register scoreboard events for this cycle.
    always_comb begin
        // NOTE: every comb output gets a default before the loop, so no path leaves it unassigned (no latch).
        set_vec = '0;
        clr_vec = '0;
        for (int r = 1; r < NREG; r++) begin
            set_vec[r] = (iss_en[0] && iss_a[0 +: AW] == AW'(r)) ||
                         (iss_en[1] && iss_a[AW +: AW] == AW'(r));
            clr_vec[r] = ((|we0) && wa0 == AW'(r)) ||
                         ((|we1) && wa1 == AW'(r));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the storage array is reset explicitly because a reset clear of all registers is architectural.
            for (int r = 0; r < NREG; r++) begin
                mem[r] <= '0;
            end
            busy <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                for (int b = 0; b < NB; b++) begin
                    // NOTE: non-blocking updates keep every register's next state based on pre-edge values.
                    if (we1[b] && wa1 == AW'(r)) begin
                        mem[r][8*b +: 8] <= wd1[8*b +: 8];
                    end else if (we0[b] && wa0 == AW'(r)) begin
                        mem[r][8*b +: 8] <= wd0[8*b +: 8];
                    end
                end
                // A new producer issued in the same cycle as the old one retires keeps the bit set.
                if (set_vec[r]) begin
                    busy[r] <= 1'b1;
                end else if (clr_vec[r]) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        logic [AW-1:0] a;
        logic [DW-1:0] word;
        a       = '0;
        word    = '0;
        rd      = '0;
        rd_busy = '0;
        for (int k = 0; k < NR; k++) begin
            a    = ra[k*AW +: AW];
            word = '0;
            if (rst && in_range(a)) begin
                word = mem[a];
`ifdef REGFILE_BYPASS_EN
                for (int b = 0; b < NB; b++) begin
                    if (we1[b] && wa1 == a) begin
                        word[8*b +: 8] = wd1[8*b +: 8];
                    end else if (we0[b] && wa0 == a) begin
                        word[8*b +: 8] = wd0[8*b +: 8];
                    end
                end
                rd_busy[k] = busy[a] && !(clr_vec[a] && !set_vec[a]);
`else
                rd_busy[k] = busy[a];
`endif
            end
            rd[k*DW +: DW] = word;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized self-checking bench for regfile_mp against an array-based reference model.
// Follows REGFILE_BYPASS_EN the same way the design does.
module tb_regfile_mp;

    localparam int DW   = 32;
    localparam int NREG = 24;
    localparam int AW   = 5;
    localparam int NR   = 2;
    localparam int NB   = DW / 8;

    logic              clk;
    logic              rst;
    logic [NR*AW-1:0]  ra;
    logic [NR*DW-1:0]  rd;
    logic [NR-1:0]     rd_busy;
    logic [NB-1:0]     we0, we1;
    logic [AW-1:0]     wa0, wa1;
    logic [DW-1:0]     wd0, wd1;
    logic [1:0]        iss_en;
    logic [2*AW-1:0]   iss_a;

    int checks;
    int failures;

    logic [DW-1:0] model [NREG];
    bit            busy_m [NREG];
    bit            in_reset;

    regfile_mp #(.DW(DW), .NREG(NREG), .AW(AW), .NR(NR)) dut (
        .clk     (clk),
        .rst     (rst),
        .ra      (ra),
        .rd      (rd),
        .rd_busy (rd_busy),
        .we0     (we0),
        .wa0     (wa0),
        .wd0     (wd0),
        .we1     (we1),
        .wa1     (wa1),
        .wd1     (wd1),
        .iss_en  (iss_en),
        .iss_a   (iss_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit valid_addr(input logic [AW-1:0] a);
        return (a != 0) && (int'(a) < NREG);
    endfunction

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        if (in_reset || !valid_addr(a)) return '0;
        v = model[a];
`ifdef REGFILE_BYPASS_EN
        // In-flight writes land in lane order, so the younger lane overwrites.
        for (int b = 0; b < NB; b++) if (we0[b] && wa0 == a) v[8*b +: 8] = wd0[8*b +: 8];
        for (int b = 0; b < NB; b++) if (we1[b] && wa1 == a) v[8*b +: 8] = wd1[8*b +: 8];
`endif
        return v;
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a);
        bit written, marked;
        if (in_reset || !valid_addr(a)) return 1'b0;
        written = ((|we0) && wa0 == a) || ((|we1) && wa1 == a);
        marked  = (iss_en[0] && iss_a[0 +: AW] == a) || (iss_en[1] && iss_a[AW +: AW] == a);
`ifdef REGFILE_BYPASS_EN
        if (written && !marked) return 1'b0;
`else
        if (written && marked) return busy_m[a];
`endif
        return busy_m[a];
    endfunction

    task automatic clear_model();
        for (int r = 0; r < NREG; r++) begin
            model[r]  = '0;
            busy_m[r] = 1'b0;
        end
    endtask

    task automatic idle();
        we0 = '0; wa0 = '0; wd0 = '0;
        we1 = '0; wa1 = '0; wd1 = '0;
        iss_en = '0; iss_a = '0;
    endtask

    task automatic check_outputs(input string tag);
        #1;
        for (int k = 0; k < NR; k++) begin
            check($sformatf("%s_rd%0d", tag, k), rd[k*DW +: DW], exp_rd(ra[k*AW +: AW]));
            check($sformatf("%s_busy%0d", tag, k), 32'(rd_busy[k]), 32'(exp_busy(ra[k*AW +: AW])));
        end
    endtask

    // Advance one clock and apply this cycle's writes and marks to the model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            if (valid_addr(wa0)) for (int b = 0; b < NB; b++) if (we0[b]) model[wa0][8*b +: 8] = wd0[8*b +: 8];
            if (valid_addr(wa1)) for (int b = 0; b < NB; b++) if (we1[b]) model[wa1][8*b +: 8] = wd1[8*b +: 8];
            if ((|we0) && valid_addr(wa0)) busy_m[wa0] = 1'b0;
            if ((|we1) && valid_addr(wa1)) busy_m[wa1] = 1'b0;
            for (int j = 0; j < 2; j++) begin
                if (iss_en[j] && valid_addr(iss_a[j*AW +: AW])) busy_m[iss_a[j*AW +: AW]] = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic write0(input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] d);
        idle();
        we0 = be; wa0 = a; wd0 = d;
        tick();
        idle();
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 31));
        return AW'($urandom_range(0, 9));
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        idle();
        ra       = '0;
        rst      = 1'b0;
        in_reset = 1'b1;
        clear_model();
        @(negedge clk);
        ra[0 +: AW] = 5'd3; ra[AW +: AW] = 5'd7;
        check_outputs("reset_state");
        @(negedge clk);
        rst = 1'b1;
        in_reset = 1'b0;

        // Reset mid-run clears stored data immediately.
        write0(5'd5, 4'hF, 32'hDEAD_BEEF);
        iss_en = 2'b01; iss_a[0 +: AW] = 5'd6;
        tick();
        idle();
        ra[0 +: AW] = 5'd5; ra[AW +: AW] = 5'd6;
        #1;
        check("pre_reset_val", rd[0 +: DW], 32'hDEAD_BEEF);
        check("pre_reset_busy", 32'(rd_busy[1]), 32'd1);
        rst = 1'b0;
        in_reset = 1'b1;
        clear_model();
        #1;
        check("async_reset_rd", rd[0 +: DW], 32'h0);
        check("async_reset_busy", 32'(rd_busy), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        in_reset = 1'b0;
        check_outputs("post_reset");

        // Partial write merges into existing bytes.
        write0(5'd3, 4'hF, 32'hAAAA_AAAA);
        write0(5'd3, 4'b0011, 32'h1234_5678);
        ra[0 +: AW] = 5'd3;
        #1;
        check("partial_write", rd[0 +: DW], 32'hAAAA_5678);

        // Same-address dual write: port 1 wins overlapping bytes.
        we0 = 4'hF;    wa0 = 5'd7; wd0 = 32'h1111_1111;
        we1 = 4'b1100; wa1 = 5'd7; wd1 = 32'h2222_2222;
        tick();
        idle();
        ra[0 +: AW] = 5'd7;
        #1;
        check("dual_write_merge", rd[0 +: DW], 32'h2222_1111);

        // Register 0 ignores writes and issue marks.
        we0 = 4'hF; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
        we1 = 4'hF; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF;
        iss_en = 2'b11; iss_a = '0;
        tick();
        idle();
        ra[0 +: AW] = 5'd0;
        #1;
        check("reg0_read", rd[0 +: DW], 32'h0);
        check("reg0_busy", 32'(rd_busy[0]), 32'h0);

        // Scoreboard: set, set-wins-over-clear, then clear.
        iss_en = 2'b01; iss_a[0 +: AW] = 5'd9;
        tick();
        idle();
        ra[0 +: AW] = 5'd9;
        #1;
        check("busy_set", 32'(rd_busy[0]), 32'd1);
        we1 = 4'hF; wa1 = 5'd9; wd1 = 32'h0000_0099;
        iss_en = 2'b10; iss_a[AW +: AW] = 5'd9;
        tick();
        idle();
        #1;
        check("busy_set_wins", 32'(rd_busy[0]), 32'd1);
        we0 = 4'hF; wa0 = 5'd9; wd0 = 32'h0000_0909;
        tick();
        idle();
        #1;
        check("busy_cleared", 32'(rd_busy[0]), 32'd0);

        // Same-cycle read of an in-flight write.
        write0(5'd4, 4'hF, 32'h0102_0304);
        iss_en = 2'b01; iss_a[0 +: AW] = 5'd4;
        tick();
        idle();
        we0 = 4'hF; wa0 = 5'd4; wd0 = 32'hCAFE_F00D;
        ra[0 +: AW] = 5'd4;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_rd", rd[0 +: DW], 32'hCAFE_F00D);
        check("bypass_busy", 32'(rd_busy[0]), 32'd0);
`else
        check("nobypass_rd", rd[0 +: DW], 32'h0102_0304);
        check("nobypass_busy", 32'(rd_busy[0]), 32'd1);
`endif
        tick();
        idle();
        #1;
        check("write_visible", rd[0 +: DW], 32'hCAFE_F00D);
        check("write_busy_clr", 32'(rd_busy[0]), 32'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            we0 = ($urandom_range(0, 3) == 0) ? '0 : NB'($urandom);
            we1 = ($urandom_range(0, 3) == 0) ? '0 : NB'($urandom);
            wa0 = rand_addr(); wa1 = rand_addr();
            wd0 = $urandom;    wd1 = $urandom;
            iss_en = 2'($urandom);
            iss_a  = {rand_addr(), rand_addr()};
            ra     = {rand_addr(), rand_addr()};
            check_outputs("rand");
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
